// File: rtl/dcache_mem_responder_if.sv
// Line-granular request/grant bus between the data cache (master) and the
// backing-store responder (slave).
interface dcache_mem_responder_if #(
  parameter int LINE_ADDR_LEN = 3,
  parameter int ADDR_LEN      = 10
);
  localparam int LINE_W = 32 << LINE_ADDR_LEN;

  logic                mem_rd_req;
  logic                mem_wr_req;
  logic [ADDR_LEN-1:0] mem_addr;
  logic [LINE_W-1:0]   mem_wr_line;
  logic [LINE_W-1:0]   mem_rd_line;
  logic                mem_gnt;
  logic                mem_busy;

  modport master (
    output mem_rd_req, mem_wr_req, mem_addr, mem_wr_line,
    input  mem_rd_line, mem_gnt, mem_busy
  );

  modport slave (
    input  mem_rd_req, mem_wr_req, mem_addr, mem_wr_line,
    output mem_rd_line, mem_gnt, mem_busy
  );
endinterface

// File: rtl/dcache_mem_responder.sv
// Backing-store responder for the data cache: accepts one line read or write,
// waits a fixed latency, then pulses mem_gnt for one cycle.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | sampling requests; write wins if both are high
// BUSY   | latency down-counter running; bus inputs ignored
// DONE   | one-cycle grant; read data already registered, write commits
//        | on the edge leaving this state
module dcache_mem_responder #(
  parameter int LINE_ADDR_LEN = 3,
  parameter int ADDR_LEN      = 10,
  parameter int MEM_LATENCY   = 50
) (
  input logic                    clk,
  input logic                    rst,
  dcache_mem_responder_if.slave  bus
);
  localparam int WORDS   = 1 << LINE_ADDR_LEN;
  localparam int LINE_W  = 32 * WORDS;
  localparam int WADDR_W = ADDR_LEN + LINE_ADDR_LEN;
  localparam int DEPTH   = 1 << WADDR_W;
  localparam int CNT_W   = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                op_wr_q, op_wr_d;
  logic [ADDR_LEN-1:0] addr_q, addr_d;
  logic [LINE_W-1:0]   wdata_q, wdata_d;
  logic [LINE_W-1:0]   rd_line_q, rd_line_d;
  logic [LINE_W-1:0]   line_rd;
  logic                mem_we;

  logic [31:0] mem_q [DEPTH];

  // Gather the captured line's words out of the word array.
  always_comb begin
    line_rd = '0;
    for (int i = 0; i < WORDS; i++) begin
      line_rd[32*i +: 32] = mem_q[{addr_q, LINE_ADDR_LEN'(i)}];
    end
  end

  // FSM next-state, request capture, latency countdown and read-data load.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_wr_d   = op_wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rd_line_d = rd_line_q;
    mem_we    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.mem_wr_req || bus.mem_rd_req) begin
          op_wr_d = bus.mem_wr_req;
          addr_d  = bus.mem_addr;
          if (bus.mem_wr_req) begin
            wdata_d = bus.mem_wr_line;
          end
          cnt_d   = CNT_LOAD;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (cnt_q == '0) begin
          state_d = S_DONE;
          if (!op_wr_q) begin
            rd_line_d = line_rd;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DONE: begin
        mem_we  = op_wr_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and data registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_wr_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rd_line_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_wr_q   <= op_wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rd_line_q <= rd_line_d;
    end
  end

  // Storage keeps its contents across reset; a reset in DONE drops the write.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      for (int i = 0; i < WORDS; i++) begin
        mem_q[{addr_q, LINE_ADDR_LEN'(i)}] <= wdata_q[32*i +: 32];
      end
    end
  end

  assign bus.mem_gnt     = (state_q == S_DONE);
  assign bus.mem_busy    = (state_q != S_IDLE);
  assign bus.mem_rd_line = rd_line_q;

endmodule

// File: tb/tb_dcache_mem_responder.sv
module tb_dcache_mem_responder;
  localparam int L   = 4;
  localparam int LAL = 3;
  localparam int AL  = 10;
  localparam int LW  = 32 << LAL;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dcache_mem_responder_if #(.LINE_ADDR_LEN(LAL), .ADDR_LEN(AL)) bus ();

  dcache_mem_responder #(
    .LINE_ADDR_LEN(LAL),
    .ADDR_LEN(AL),
    .MEM_LATENCY(L)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  // Transaction-level timeline model: one in-flight op, granted L edges
  // after acceptance, write committed on the following edge.
  int                e = 0;
  bit                started = 1'b0;
  bit                m_busy = 1'b0;
  int                m_acc = 0;
  bit                m_wr = 1'b0;
  logic [AL-1:0]     m_addr = '0;
  logic [LW-1:0]     m_data = '0;
  logic [LW-1:0]     exp_rd = '0;
  bit                rd_known = 1'b0;
  logic [LW-1:0]     mdl [int];

  always @(posedge clk) begin
    e++;
    started = 1'b1;
    if (rst) begin
      m_busy   = 1'b0;
      exp_rd   = '0;
      rd_known = 1'b1;
    end else if (m_busy) begin
      if (e == m_acc + L) begin
        if (!m_wr) begin
          if (mdl.exists(int'(m_addr))) begin
            exp_rd   = mdl[int'(m_addr)];
            rd_known = 1'b1;
          end else begin
            rd_known = 1'b0;
          end
        end
      end else if (e == m_acc + L + 1) begin
        if (m_wr) mdl[int'(m_addr)] = m_data;
        m_busy = 1'b0;
      end
    end else if (bus.mem_wr_req || bus.mem_rd_req) begin
      m_busy = 1'b1;
      m_acc  = e;
      m_wr   = bus.mem_wr_req;
      m_addr = bus.mem_addr;
      m_data = bus.mem_wr_line;
    end
  end

  task automatic chk_line(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_w32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_bit(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (started) begin
      chk_bit("gnt", bus.mem_gnt, m_busy && (e == m_acc + L));
      chk_bit("busy", bus.mem_busy, m_busy);
      if (rd_known) chk_line("rd_line", bus.mem_rd_line, exp_rd);
    end
  end

  function automatic logic [LW-1:0] fill(input logic [31:0] base, input bit inc);
    logic [LW-1:0] v;
    v = '0;
    for (int i = 0; i < LW / 32; i++) begin
      v[32*i +: 32] = inc ? base + 32'(i) : base;
    end
    return v;
  endfunction

  task automatic wait_gnt(output int g);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.mem_gnt && n < 200);
    if (!bus.mem_gnt) begin
      checks++;
      errors++;
      $display("FAIL gnt_timeout: got no grant expected grant within %0d cycles", n);
    end
    g = e;
  endtask

  task automatic txn(input bit wr, input logic [AL-1:0] a, input logic [LW-1:0] d, output int lat);
    int e0, g;
    @(negedge clk);
    bus.mem_wr_req  = wr;
    bus.mem_rd_req  = !wr;
    bus.mem_addr    = a;
    bus.mem_wr_line = d;
    e0 = e;
    wait_gnt(g);
    lat = g - (e0 + 1);
    bus.mem_wr_req = 1'b0;
    bus.mem_rd_req = 1'b0;
  endtask

  initial begin
    int lat, e0, g1, g2, ng;
    bus.mem_rd_req  = 1'b0;
    bus.mem_wr_req  = 1'b1;
    bus.mem_addr    = 10'h005;
    bus.mem_wr_line = fill(32'hFFFF0000, 1'b1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_bit("rst_gnt", bus.mem_gnt, 1'b0);
    chk_bit("rst_busy", bus.mem_busy, 1'b0);
    chk_line("rst_rd_line", bus.mem_rd_line, '0);
    rst = 1'b0;
    bus.mem_wr_req = 1'b0;
    @(negedge clk);
    chk_bit("rst_req_ignored", bus.mem_busy, 1'b0);

    // write then read
    txn(1'b1, 10'h005, fill(32'hA0000000, 1'b1), lat);
    chk_int("wr_latency", lat, 4);
    @(negedge clk);
    chk_bit("gnt_width", bus.mem_gnt, 1'b0);
    txn(1'b0, 10'h005, '0, lat);
    chk_int("rd_latency", lat, 4);
    chk_w32("rd_word7", bus.mem_rd_line[255:224], 32'hA0000007);
    chk_w32("rd_word0", bus.mem_rd_line[31:0], 32'hA0000000);

    // simultaneous write and read to 0x3FF
    @(negedge clk);
    bus.mem_wr_req  = 1'b1;
    bus.mem_rd_req  = 1'b1;
    bus.mem_addr    = 10'h3FF;
    bus.mem_wr_line = fill(32'h11111111, 1'b0);
    e0 = e;
    wait_gnt(g1);
    chk_int("simul_wr_latency", g1 - (e0 + 1), 4);
    chk_line("simul_wr_first", bus.mem_rd_line, fill(32'hA0000000, 1'b1));
    bus.mem_wr_req = 1'b0;
    wait_gnt(g2);
    chk_int("simul_rd_gap", g2 - g1, 6);
    chk_line("simul_rd_data", bus.mem_rd_line, fill(32'h11111111, 1'b0));
    bus.mem_rd_req = 1'b0;

    // inputs changed while a write to 0x010 is in flight
    txn(1'b1, 10'h011, fill(32'h55000000, 1'b1), lat);
    @(negedge clk);
    bus.mem_wr_req  = 1'b1;
    bus.mem_addr    = 10'h010;
    bus.mem_wr_line = fill(32'hC0DE0000, 1'b1);
    repeat (2) @(negedge clk);
    bus.mem_addr    = 10'h011;
    bus.mem_wr_line = fill(32'hBAD00000, 1'b1);
    wait_gnt(g1);
    bus.mem_wr_req = 1'b0;
    txn(1'b0, 10'h010, '0, lat);
    chk_line("midflight_010", bus.mem_rd_line, fill(32'hC0DE0000, 1'b1));
    txn(1'b0, 10'h011, '0, lat);
    chk_line("midflight_011", bus.mem_rd_line, fill(32'h55000000, 1'b1));

    // reset during BUSY aborts the write to 0x020
    txn(1'b1, 10'h020, fill(32'h12340000, 1'b1), lat);
    @(negedge clk);
    bus.mem_wr_req  = 1'b1;
    bus.mem_addr    = 10'h020;
    bus.mem_wr_line = fill(32'hDEADBEEF, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    bus.mem_wr_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk_bit("rst_mid_busy", bus.mem_busy, 1'b0);
    ng = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.mem_gnt) ng++;
    end
    chk_int("rst_mid_no_gnt", ng, 0);
    txn(1'b0, 10'h020, '0, lat);
    chk_line("rst_mid_prior", bus.mem_rd_line, fill(32'h12340000, 1'b1));

    // reset in DONE drops the write to 0x030
    txn(1'b1, 10'h030, fill(32'h77770000, 1'b1), lat);
    @(negedge clk);
    bus.mem_wr_req  = 1'b1;
    bus.mem_addr    = 10'h030;
    bus.mem_wr_line = fill(32'h99990000, 1'b1);
    wait_gnt(g1);
    rst = 1'b1;
    bus.mem_wr_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk_bit("rst_done_gnt", bus.mem_gnt, 1'b0);
    txn(1'b0, 10'h030, '0, lat);
    chk_line("rst_done_prior", bus.mem_rd_line, fill(32'h77770000, 1'b1));

    // read data holds across writes
    txn(1'b1, 10'h100, fill(32'h01000000, 1'b1), lat);
    txn(1'b1, 10'h101, fill(32'h01010000, 1'b1), lat);
    chk_line("hold_after_wr", bus.mem_rd_line, fill(32'h77770000, 1'b1));

    // back-to-back reads with request held high
    @(negedge clk);
    bus.mem_rd_req = 1'b1;
    bus.mem_addr   = 10'h100;
    wait_gnt(g1);
    bus.mem_addr = 10'h101;
    chk_line("b2b_first", bus.mem_rd_line, fill(32'h01000000, 1'b1));
    @(negedge clk);
    chk_bit("b2b_idle_gap", bus.mem_busy, 1'b0);
    wait_gnt(g2);
    bus.mem_rd_req = 1'b0;
    chk_int("b2b_gap", g2 - g1, 6);
    chk_line("b2b_second", bus.mem_rd_line, fill(32'h01010000, 1'b1));

    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dcache_mem_responder.md
Name: dcache_mem_responder

Overview:
- Main-memory side of the data-cache refill/writeback interface: the responder that the data cache in the WB stage talks to when it raises CacheMiss.
- Accepts one line-granular read or write request, models a fixed access latency, then returns a single-cycle grant. For reads, the grant comes with the line data.
- Used in simulation and on the Nexys4 build as the backing store behind the data cache.

Parameters:
- LINE_ADDR_LEN, 3, log2(words per line); line width = 32<<LINE_ADDR_LEN bits.
- ADDR_LEN, 10, line-address width; capacity = 2^ADDR_LEN lines.
- MEM_LATENCY, 50, cycles from request acceptance to grant; legal range >=1.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- mem_rd_req  input  1  line read request, level; held until grant.
- mem_wr_req  input  1  line write request, level; held until grant.
- mem_addr  input  ADDR_LEN  line address.
- mem_wr_line  input  32<<LINE_ADDR_LEN  write data; word i at bits [32i+31:32i].
- mem_rd_line  output  32<<LINE_ADDR_LEN  read data; valid in the grant cycle and held afterwards.
- mem_gnt  output  1  one-cycle completion pulse.
- mem_busy  output  1  high while a request is in flight (BUSY or DONE).

Behaviour:
- Clocking and reset:
  - Single clock. Reset is synchronous and active-high: clk and rst, polarity and synchronicity fixed.
  - Reset outputs: mem_gnt=0, mem_busy=0, mem_rd_line=0, state=IDLE, latency counter=0.
  - Storage array is not cleared by rst.
- Storage: word array of 2^(ADDR_LEN+LINE_ADDR_LEN) x 32. Word i of line A sits at word index {A, i[LINE_ADDR_LEN-1:0]}.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - Samples mem_rd_req/mem_wr_req every edge.
  - If either is high, it captures mem_addr, the operation and mem_wr_line (for writes) into internal registers.
  - It then loads counter = MEM_LATENCY-1 and moves to BUSY.
- Request priority: if both requests are high at the same edge, the write is accepted and the read stays pending. The requester keeps mem_rd_req high; the read is accepted in a later IDLE cycle.
- BUSY:
  - Decrements the counter each edge; moves to DONE when the counter reaches 0.
  - Request and address inputs are ignored; the captured values govern the transaction.
- DONE (exactly one cycle):
  - mem_gnt=1.
  - Read: mem_rd_line presents the captured line. The array read is registered on the BUSY->DONE edge.
  - Write: the array is updated at the DONE->IDLE edge with the captured data.
  - Always returns to IDLE.
- Latency: request accepted at edge k means mem_gnt is high during the cycle following edge k+MEM_LATENCY. With MEM_LATENCY=1, BUSY lasts one cycle.
- Handshake:
  - The requester must deassert the granted request by the first IDLE cycle after the grant.
  - A request still high in IDLE is treated as new, so back-to-back transactions have a 1-cycle IDLE gap minimum.
- mem_rd_line holds its last read value across writes and idle cycles; it changes only on read completion or rst.
- Ordering: a read accepted after a write's grant returns the written data (write committed before next IDLE sample).
- Reset mid-operation: the transaction is aborted and state returns to IDLE.
  - Reset during BUSY: no array write.
  - Reset in DONE: the write is not committed, and mem_gnt drops next cycle.
- mem_busy=1 in BUSY and DONE, 0 in IDLE.

Test Plan:
- All tests use MEM_LATENCY=4, LINE_ADDR_LEN=3, ADDR_LEN=10.
- Reset: hold rst 2 cycles -> mem_gnt=0, mem_busy=0, mem_rd_line=0. Requests asserted during rst are ignored.
- Write then read:
  - Write addr 0x05 with words i = 0xA0000000+i; grant comes exactly 4 cycles after acceptance, pulse 1 cycle wide.
  - Then read addr 0x05 -> grant after 4 cycles, mem_rd_line word7=0xA0000007, word0=0xA0000000.
- Simultaneous requests: wr addr 0x3FF (data all 0x11111111) and rd addr 0x3FF asserted together.
  - Write granted first; the still-held read is accepted after 1 IDLE cycle and returns 0x11111111 in all words.
- Input change mid-flight: change mem_addr/mem_wr_line during BUSY of a write to 0x010.
  - Only the originally captured data lands at 0x010; other addresses are unchanged.
- Reset mid-operation: assert rst 2 cycles after a write to 0x020 (data 0xDEADBEEF) is accepted.
  - No grant is produced; a subsequent read of 0x020 returns the prior contents.
  - mem_busy=0 the cycle after rst.
- Hold/back-to-back:
  - After a read grant, issue writes only; mem_rd_line stays at the last read value.
  - Two back-to-back reads are separated by exactly one IDLE cycle between grant and next acceptance.
